image_mem_arbiter: RTL and testbench

//  Shares the single-port display image memory between two requesters:
//  - display scan-out reader (DISP): read-only, latency-critical.
//  - processor store/load port (CPU): read and write.

---
 rtl/image_mem_arbiter.sv | 72 +++++++
 tb/tb_image_mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter: shares the single-port image memory between display scan-out and CPU, with a starvation guard for the CPU
module image_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);

    typedef enum logic {DISP_PRI, CPU_FORCE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            own_disp_q, own_disp_d;
    logic            own_cpu_q, own_cpu_d;
    logic            cpu_win;

    always_comb begin
        cpu_win     = cpu_req && (state_q == CPU_FORCE || !disp_req);
        cpu_gnt     = rst_n && cpu_win;
        disp_gnt    = rst_n && disp_req && !cpu_win;
        streak_d    = (!cpu_req || cpu_gnt) ? '0 : disp_gnt ? streak_q + 1'b1 : streak_q;
        state_d     = (state_q == DISP_PRI) ? ((streak_d == STREAK_LIM) ? CPU_FORCE : DISP_PRI)
                                            : ((cpu_gnt || !cpu_req) ? DISP_PRI : CPU_FORCE);
        own_disp_d  = disp_gnt;
        own_cpu_d   = cpu_gnt && !cpu_we;
        mem_en      = disp_gnt || cpu_gnt;
        mem_we      = cpu_gnt && cpu_we;
        mem_re      = disp_gnt || own_cpu_d;
        mem_addr    = disp_gnt ? disp_addr : cpu_gnt ? cpu_addr : '0;
        mem_wdata   = mem_we ? cpu_wdata : '0;
        disp_rvalid = own_disp_q;
        disp_rdata  = own_disp_q ? mem_rdata : '0;
        cpu_rvalid  = own_cpu_q;
        cpu_rdata   = own_cpu_q ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISP_PRI;
            streak_q   <= '0;
            own_disp_q <= 1'b0;
            own_cpu_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            own_disp_q <= own_disp_d;
            own_cpu_q  <= own_cpu_d;
        end
    end
endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb_image_mem_arbiter: directed checks of grant priority, starvation guard, read return and reset
module tb_image_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req, disp_gnt, disp_rvalid;
    logic [14:0] disp_addr;
    logic [15:0] disp_rdata;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        mem_en, mem_we, mem_re;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem [0:32767];
    int          n_tests = 0;
    int          n_fail = 0;

    image_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM: a write is visible to a read in the following cycle
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (mem_en && mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [14:0] da, input logic cr, input logic cw,
                         input logic [14:0] ca, input logic [15:0] cd);
        @(negedge clk);
        disp_req = dr; disp_addr = da;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dgnt"}, disp_gnt, 0);
        chk({tag, "_cgnt"}, cpu_gnt, 0);
        chk({tag, "_drv"}, disp_rvalid, 0);
        chk({tag, "_crv"}, cpu_rvalid, 0);
        chk({tag, "_drd"}, disp_rdata, 0);
        chk({tag, "_crd"}, cpu_rdata, 0);
        chk({tag, "_mem"}, {mem_en, mem_we, mem_re}, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
        mem_rdata = 16'h5555;
        rst_n = 1'b0;
        disp_req = 1'b1; disp_addr = 15'h0003;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0007; cpu_wdata = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("rst");

        // display-only burst; data returns one cycle after each grant
        @(negedge clk);
        rst_n = 1'b1;
        disp_req = 1'b0; cpu_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(c < 4, 15'(c), 1'b0, 1'b0, 15'h0, 16'h0);
            chk("d_gnt", disp_gnt, c < 4);
            chk("d_cgnt", cpu_gnt, 0);
            if (c < 4) chk("d_maddr", {mem_en, mem_re, mem_we, 1'b0, mem_addr}, {4'b1100, 15'(c)});
            chk("d_rv", disp_rvalid, c >= 1 && c <= 4);
            if (c >= 1 && c <= 4) chk("d_rd", disp_rdata, 16'hA000 + 16'(c - 1));
            chk("d_crv", {cpu_rvalid, cpu_rdata}, 0);
        end

        // CPU write then read back
        drive(0, 0, 1, 1, 15'h0100, 16'h1234);
        chk("cw_gnt", cpu_gnt, 1);
        chk("cw_mem", {mem_en, mem_we, mem_re}, 3'b110);
        chk("cw_wd", mem_wdata, 16'h1234);
        drive(0, 0, 1, 0, 15'h0100, 16'h0);
        chk("cr_gnt", cpu_gnt, 1);
        chk("cr_mem", {mem_en, mem_we, mem_re}, 3'b101);
        chk("cw_norv", cpu_rvalid, 0);
        drive(0, 0, 0, 0, 15'h0, 16'h0);
        chk("cr_rv", cpu_rvalid, 1);
        chk("cr_rd", cpu_rdata, 16'h1234);
        chk("cr_drd", {disp_rvalid, disp_rdata}, 0);
        drive(0, 0, 0, 0, 15'h0, 16'h0);
        chk("cr_rv1", cpu_rvalid, 0);

        // contention: eight DISP grants, then the CPU is forced through
        for (int k = 0; k < 12; k++) begin
            drive(1, 15'h0000, 1, 0, 15'h0100, 16'h0);
            chk("st_both", disp_gnt & cpu_gnt, 0);
            chk("st_dgnt", disp_gnt, k != 8);
            chk("st_cgnt", cpu_gnt, k == 8);
            if (k == 9) chk("st_crd", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h1234});
            if (k == 9) chk("st_drv", disp_rvalid, 0);
        end
        drive(0, 0, 0, 0, 15'h0, 16'h0);

        // CPU write immediately followed by DISP read of the same address
        drive(0, 0, 1, 1, 15'h0200, 16'hBEEF);
        chk("wr_gnt", cpu_gnt, 1);
        drive(1, 15'h0200, 0, 0, 15'h0, 16'h0);
        chk("wr_dgnt", disp_gnt, 1);
        drive(0, 0, 0, 0, 15'h0, 16'h0);
        chk("wr_rd", {disp_rvalid, disp_rdata}, {1'b1, 16'hBEEF});

        // reset right after a DISP read grant drops the pending return
        drive(1, 15'h0001, 0, 0, 15'h0, 16'h0);
        chk("rm_gnt", disp_gnt, 1);
        @(negedge clk);
        rst_n = 1'b0; disp_req = 1'b0;
        #1;
        chk_quiet("rm");
        @(negedge clk);
        rst_n = 1'b1; disp_req = 1'b1; disp_addr = 15'h0002;
        #1;
        chk("rm_rel_gnt", disp_gnt, 1);
        chk("rm_rel_rv", disp_rvalid, 0);
        drive(0, 0, 0, 0, 15'h0, 16'h0);
        chk("rm_rd", {disp_rvalid, disp_rdata}, {1'b1, 16'hA002});

        // CPU gives up while forced: back to DISP priority with a fresh streak
        for (int k = 0; k < 18; k++) begin
            drive(1, 15'h0000, k != 8, 0, 15'h0100, 16'h0);
            chk("fd_both", disp_gnt & cpu_gnt, 0);
            chk("fd_dgnt", disp_gnt, k != 17);
            chk("fd_cgnt", cpu_gnt, k == 17);
        end
        drive(0, 0, 0, 0, 15'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
